// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: transfer descriptor, timing configuration and the
// transfer-scheduler state encoding.
package hyperbus_pkg;

  localparam int unsigned NumReq = 2;

  typedef logic [15:0] hyper_blen_t;

  typedef struct packed {
    logic [31:0] address;
    logic        write;
    logic        address_space;
    logic        burst_type;
    hyper_blen_t burst;
  } hyper_tf_t;

  typedef struct packed {
    logic [3:0]  t_latency_access;
    logic [3:0]  t_read_write_recovery;
    logic [15:0] t_burst_max;
  } hyper_cfg_t;

  typedef enum logic [1:0] {
    Idle,
    Issue,
    Wait
  } hyper_sched_state_t;

  // A zero limit means unlimited, so the whole remainder goes out at once.
  function automatic hyper_blen_t chunk_len(input hyper_blen_t remaining,
                                            input logic [15:0] max_len);
    if (max_len == 16'd0 || 16'(remaining) <= max_len) return remaining;
    else return max_len;
  endfunction

  function automatic logic is_last(input hyper_blen_t remaining,
                                   input logic [15:0] max_len);
    return (max_len == 16'd0) || (16'(remaining) <= max_len);
  endfunction

endpackage

// File: rtl/hyperbus_burst_split.sv
// Burst splitter: tracks remaining words, current address and the latched
// chunk limit, and presents the descriptor of the next chunk to be issued.
module hyperbus_burst_split
  import hyperbus_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_addr_i,
  input  hyper_blen_t load_burst_i,
  input  logic [15:0] load_max_i,
  input  logic        advance_i,
  output logic [31:0] next_addr_o,
  output hyper_blen_t next_chunk_o,
  output logic        next_last_o,
  output logic        more_o
);

  hyper_blen_t rem_q, rem_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] max_q, max_d;
  hyper_blen_t cur_chunk;

  assign cur_chunk = chunk_len(rem_q, max_q);

  always_comb begin
    rem_d  = rem_q;
    addr_d = addr_q;
    max_d  = max_q;
    if (load_i) begin
      rem_d  = load_burst_i;
      addr_d = load_addr_i;
      max_d  = load_max_i;
    end else if (advance_i) begin
      // Addresses count bytes while bursts count 16-bit words.
      rem_d  = rem_q - cur_chunk;
      addr_d = addr_q + {15'd0, cur_chunk, 1'b0};
    end
  end

  // "Next" views are taken from the post-update values so the top can
  // register the upcoming chunk in the same cycle it commits to it.
  assign next_addr_o  = addr_d;
  assign next_chunk_o = chunk_len(rem_d, max_d);
  assign next_last_o  = is_last(rem_d, max_d);
  assign more_o       = (rem_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      addr_q <= '0;
      max_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      addr_q <= addr_d;
      max_q  <= max_d;
    end
  end

endmodule

// File: rtl/hyperbus_tf_sched.sv
// Round-robin transfer scheduler between the read/write front-ends and the
// HyperBus PHY. Define HYPERBUS_TF_SPLIT_EN to split long bursts into chunks.
module hyperbus_tf_sched
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumReq = hyperbus_pkg::NumReq
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  hyper_cfg_t             cfg_i,
  input  hyper_tf_t [NumReq-1:0] req_tf_i,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  output hyper_tf_t              phy_tf_o,
  output logic                   phy_valid_o,
  input  logic                   phy_ready_i,
  input  logic                   phy_done_i,
  output logic                   grant_o,
  output logic                   last_chunk_o,
  output logic                   busy_o
);

  hyper_sched_state_t state_q, state_d;
  logic        ptr_q, grant_q, last_q;
  hyper_tf_t   phy_tf_q;
  logic        winner;
  logic        load_req, load_next, advance, to_idle;
  logic [31:0] next_addr;
  hyper_blen_t next_chunk;
  logic        next_last;
  logic        more;
  logic        unused_cfg;

  assign winner = req_valid_i[ptr_q] ? ptr_q : ~ptr_q;

`ifdef HYPERBUS_TF_SPLIT_EN
  hyperbus_burst_split u_split (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (load_req),
    .load_addr_i  (req_tf_i[winner].address),
    .load_burst_i (req_tf_i[winner].burst),
    .load_max_i   (cfg_i.t_burst_max),
    .advance_i    (advance),
    .next_addr_o  (next_addr),
    .next_chunk_o (next_chunk),
    .next_last_o  (next_last),
    .more_o       (more)
  );
  assign unused_cfg = ^{cfg_i.t_latency_access, cfg_i.t_read_write_recovery};
`else
  assign next_addr  = req_tf_i[winner].address;
  assign next_chunk = req_tf_i[winner].burst;
  assign next_last  = 1'b1;
  assign more       = 1'b0;
  assign unused_cfg = ^cfg_i;
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    load_req    = 1'b0;
    load_next   = 1'b0;
    advance     = 1'b0;
    to_idle     = 1'b0;
    unique case (state_q)
      Idle: begin
        if (|req_valid_i) begin
          req_ready_o[winner] = 1'b1;
          load_req            = 1'b1;
          state_d             = Issue;
        end
      end
      Issue: begin
        if (phy_ready_i) begin
          advance = 1'b1;
          state_d = Wait;
        end
      end
      Wait: begin
        if (phy_done_i) begin
          if (more) begin
            load_next = 1'b1;
            state_d   = Issue;
          end else begin
            to_idle = 1'b1;
            state_d = Idle;
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= Idle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q    <= 1'b0;
      grant_q  <= 1'b0;
      last_q   <= 1'b0;
      phy_tf_q <= '0;
    end else begin
      if (load_req) begin
        grant_q                <= winner;
        phy_tf_q.write         <= req_tf_i[winner].write;
        phy_tf_q.burst_type    <= req_tf_i[winner].burst_type;
        phy_tf_q.address_space <= req_tf_i[winner].address_space;
      end
      // Only registered outputs reach the PHY; they change solely on entry
      // to Issue, which keeps the chunk stable through backpressure.
      if (load_req || load_next) begin
        phy_tf_q.address <= next_addr;
        phy_tf_q.burst   <= next_chunk;
        last_q           <= next_last;
      end
      if (to_idle) begin
        ptr_q  <= ~grant_q;
        last_q <= 1'b0;
      end
    end
  end

  assign phy_tf_o     = phy_tf_q;
  assign phy_valid_o  = (state_q == Issue);
  assign busy_o       = (state_q != Idle);
  assign grant_o      = grant_q;
  assign last_chunk_o = last_q;

endmodule

// File: tb/tb_hyperbus_tf_sched.sv
// Directed, table-driven bench for the HyperBus transfer scheduler; expected
// chunking follows HYPERBUS_TF_SPLIT_EN.
module tb_hyperbus_tf_sched;
  import hyperbus_pkg::*;

  logic             clk;
  logic             rst;
  hyper_cfg_t       cfg;
  hyper_tf_t [1:0]  req_tf;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  hyper_tf_t        phy_tf;
  logic             phy_valid;
  logic             phy_ready;
  logic             phy_done;
  logic             grant;
  logic             last_chunk;
  logic             busy;

  int errors = 0;
  int checks = 0;

  hyperbus_tf_sched #(.NumReq(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_i        (cfg),
    .req_tf_i     (req_tf),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .phy_tf_o     (phy_tf),
    .phy_valid_o  (phy_valid),
    .phy_ready_i  (phy_ready),
    .phy_done_i   (phy_done),
    .grant_o      (grant),
    .last_chunk_o (last_chunk),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ch;
    logic        write;
    logic        asp;
    logic        btype;
    logic [31:0] addr;
    logic [15:0] burst;
    logic [15:0] max_len;
    logic [15:0] max_after;
    int          n;
    logic [15:0] step;
    logic [15:0] last_burst;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic hyper_tf_t mk_tf(input logic [31:0] addr, input logic wr,
                                      input logic asp, input logic bt,
                                      input logic [15:0] len);
    hyper_tf_t t;
    t.address       = addr;
    t.write         = wr;
    t.address_space = asp;
    t.burst_type    = bt;
    t.burst         = len;
    return t;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    phy_ready = 1'b0;
    phy_done  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // One full request from acceptance to return to Idle, PHY answering promptly.
  task automatic run_vec(input vec_t v, input int idx);
    hyper_tf_t   exp_tf;
    logic [31:0] exp_addr;
    string       tag;
    tag = $sformatf("v%0d", idx);
    req_tf[v.ch]    = mk_tf(v.addr, v.write, v.asp, v.btype, v.burst);
    req_valid       = '0;
    req_valid[v.ch] = 1'b1;
    cfg.t_burst_max = v.max_len;
    #1;
    check({tag, ".ready"}, 64'(req_ready), v.ch ? 64'd2 : 64'd1);
    tick();
    req_valid       = '0;
    cfg.t_burst_max = v.max_after;
    #1;
    check({tag, ".grant"}, 64'(grant), 64'(v.ch));
    check({tag, ".busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < v.n; i++) begin
      exp_addr = v.addr + 32'(2 * int'(v.step) * i);
      exp_tf   = mk_tf(exp_addr, v.write, v.asp, v.btype,
                       (i == v.n - 1) ? v.last_burst : v.step);
      check($sformatf("%s.c%0d.valid", tag, i), 64'(phy_valid), 64'd1);
      check($sformatf("%s.c%0d.tf", tag, i), 64'(phy_tf), 64'(exp_tf));
      check($sformatf("%s.c%0d.last", tag, i), 64'(last_chunk), 64'(i == v.n - 1));
      phy_ready = 1'b1;
      tick();
      phy_ready = 1'b0;
      check($sformatf("%s.c%0d.wait_valid", tag, i), 64'(phy_valid), 64'd0);
      tick();
      phy_done = 1'b1;
      tick();
      phy_done = 1'b0;
    end
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    check({tag, ".idle_valid"}, 64'(phy_valid), 64'd0);
  endtask

  initial begin
    bit   grants[$];
    bit   hs;
    hyper_tf_t exp_tf;

    cfg    = '0;
    req_tf = '0;

`ifdef HYPERBUS_TF_SPLIT_EN
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 16'd8,  16'd0, 16'd0, 1, 16'd0, 16'd8};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 16'd20, 16'd8, 16'd8, 3, 16'd8, 16'd4};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 16'd0,  16'd4, 16'd4, 1, 16'd0, 16'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 16'd4,  16'd4, 16'd4, 1, 16'd0, 16'd4};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 16'd5,  16'd4, 16'd4, 2, 16'd4, 16'd1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 16'd7,  16'd3, 16'd3, 3, 16'd3, 16'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 16'd8,  16'd4, 16'd2, 2, 16'd4, 16'd4};
`else
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 16'd8,  16'd0, 16'd0, 1, 16'd0, 16'd8};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 16'd20, 16'd8, 16'd8, 1, 16'd0, 16'd20};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 16'd0,  16'd4, 16'd4, 1, 16'd0, 16'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 16'd4,  16'd4, 16'd4, 1, 16'd0, 16'd4};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 16'd5,  16'd4, 16'd4, 1, 16'd0, 16'd5};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 16'd7,  16'd3, 16'd3, 1, 16'd0, 16'd7};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 16'd8,  16'd4, 16'd2, 1, 16'd0, 16'd8};
`endif

    // Reset state.
    do_reset();
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.valid", 64'(phy_valid), 64'd0);
    check("rst.tf", 64'(phy_tf), 64'd0);
    check("rst.ready", 64'(req_ready), 64'd0);
    check("rst.grant", 64'(grant), 64'd0);
    check("rst.last", 64'(last_chunk), 64'd0);

    // Both requesters valid every cycle: grants must alternate from 0.
    req_tf[0] = mk_tf(32'h0000_0080, 1'b0, 1'b0, 1'b0, 16'd2);
    req_tf[1] = mk_tf(32'h0000_0880, 1'b1, 1'b0, 1'b0, 16'd2);
    cfg.t_burst_max = 16'd0;
    req_valid = 2'b11;
    phy_ready = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      phy_done = hs;
      #1;
      check($sformatf("rr.c%0d.onehot", c), 64'(req_ready == 2'b11), 64'd0);
      if (req_ready != 2'b00) grants.push_back(req_ready[1]);
      hs = phy_valid & phy_ready;
      tick();
    end
    check("rr.count", 64'(grants.size()), 64'd4);
    for (int k = 0; k < grants.size(); k++)
      check($sformatf("rr.grant%0d", k), 64'(grants[k]), 64'(k % 2));
    do_reset();

    // Table of single-requester transfers.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // PHY backpressure for 5 cycles; a stray done in Issue must be ignored.
    exp_tf = mk_tf(32'h0000_0500, 1'b0, 1'b1, 1'b0, 16'd8);
    req_tf[0] = exp_tf;
    cfg.t_burst_max = 16'd0;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      phy_done = (k == 2);
      check($sformatf("stall%0d.valid", k), 64'(phy_valid), 64'd1);
      check($sformatf("stall%0d.tf", k), 64'(phy_tf), 64'(exp_tf));
      tick();
    end
    phy_done = 1'b0;
    check("stall.after_done.valid", 64'(phy_valid), 64'd1);
    phy_ready = 1'b1;
    tick();
    phy_ready = 1'b0;
    tick();
    phy_done = 1'b1;
    tick();
    phy_done = 1'b0;
    check("stall.idle", 64'(busy), 64'd0);

    // Reset while waiting on the first chunk; pointer must return to 0.
    run_vec('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0600, 16'd2, 16'd0, 16'd0, 1, 16'd0, 16'd2}, 7);
    req_tf[1] = mk_tf(32'h0000_0700, 1'b1, 1'b0, 1'b0, 16'd12);
    cfg.t_burst_max = 16'd4;
    req_valid = 2'b10;
    #1;
    check("mrst.ready", 64'(req_ready), 64'd2);
    tick();
    req_valid = '0;
    phy_ready = 1'b1;
    tick();
    phy_ready = 1'b0;
    check("mrst.wait", 64'(busy & ~phy_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.busy", 64'(busy), 64'd0);
    check("mrst.valid", 64'(phy_valid), 64'd0);
    check("mrst.tf", 64'(phy_tf), 64'd0);
    for (int k = 0; k < 4; k++) begin
      phy_done = (k == 1);
      tick();
      check($sformatf("mrst.quiet%0d", k), 64'({busy, phy_valid}), 64'd0);
    end
    phy_done  = 1'b0;
    req_valid = 2'b11;
    #1;
    check("mrst.ptr", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
